// File: rtl/btn_pkg.sv
// Shared constants and state encoding for the push-button conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package btn_pkg;

  // Channel index of each physical button on the board
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_FIRE  = 2;

  // Default timing at 50 MHz: 5 ms debounce, 0.5 s first repeat, 125 ms repeat rate
  localparam int unsigned DEBOUNCE_DEF      = 250000;
  localparam int unsigned REPEAT_DELAY_DEF  = 25000000;
  localparam int unsigned REPEAT_PERIOD_DEF = 6250000;

  // Per-channel debounce FSM state, kept as plain constants for the older blocks
  typedef logic [1:0] btn_state_t;
  localparam btn_state_t RELEASED     = 2'd0;
  localparam btn_state_t PRESS_WAIT   = 2'd1;
  localparam btn_state_t PRESSED      = 2'd2;
  localparam btn_state_t RELEASE_WAIT = 2'd3;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce FSM, edge pulses, optional auto-repeat, sticky event flag.
// Latency: level_n and press/release pulses change DEBOUNCE_CYCLES+3 edges after the new raw level is first sampled.
// Backpressure: none; pulses are fire-and-forget, evt_n holds low until tick. Auto-repeat built with BTN_AUTO_REPEAT_EN.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic tick,
  output logic level_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic evt_n
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             s;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             accept_press;
  logic             accept_release;

  // Bring the raw level into the clk domain; idle (released) level is 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
    end else begin
      sync1 <= btn_n;
      s     <= sync1;
    end
  end

  // A level change is accepted on the cycle the wait counter reaches its last value
  assign accept_press   = (state == PRESS_WAIT)   && !s && (cnt == CNT_LAST);
  assign accept_release = (state == RELEASE_WAIT) &&  s && (cnt == CNT_LAST);

  // Debounce FSM; the counter restarts from zero on every state change so it never wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= RELEASED;
      cnt           <= '0;
      level_n       <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= accept_press;
      release_pulse <= accept_release;
      case (state)
        RELEASED: begin
          if (!s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (accept_press) begin
            state   <= PRESSED;
            cnt     <= '0;
            level_n <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (accept_release) begin
            state   <= RELEASED;
            cnt     <= '0;
            level_n <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W = cnt_width(RPT_MAX);
  localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_first;
  logic             holding;
  logic             rpt_hit;

  // Button counts as held in PRESSED and while a release is still being debounced
  assign holding = (state == PRESSED) || (state == RELEASE_WAIT);
  assign rpt_hit = (rpt_cnt == (rpt_first ? RPT_DLY_LAST : RPT_PER_LAST));

  // Repeat timer: long first interval, then the shorter period; a confirmed release wins over a due repeat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt      <= '0;
      rpt_first    <= 1'b1;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (accept_press || accept_release || !holding) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end else if (rpt_hit) begin
        rpt_cnt      <= '0;
        rpt_first    <= 1'b0;
        repeat_pulse <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end
`else
  // Repeat timing has no effect when auto-repeat is not built
  localparam int unsigned UNUSED_RPT_CFG = REPEAT_DELAY + REPEAT_PERIOD;
  assign repeat_pulse = 1'b0;
`endif

  // Sticky event: a new press/repeat takes priority over the tick that would clear it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_n <= 1'b1;
    end else if (press_pulse || repeat_pulse) begin
      evt_n <= 1'b0;
    end else if (tick && !evt_n) begin
      evt_n <= 1'b1;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the raw active-low board buttons for the game logic: sync, debounce, pulses, sticky events.
// Latency: DEBOUNCE_CYCLES+3 clk edges from first sampling a stable raw edge to level_n/pulse outputs.
// Backpressure: none; evt_n holds each event until the game tick. Auto-repeat built with BTN_AUTO_REPEAT_EN.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int          N_BTN           = BTN_FIRE + 1,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  input  logic             tick,
  output logic [N_BTN-1:0] level_n,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic [N_BTN-1:0] evt_n
);

  // Channels are fully independent; only clk, reset and tick are shared
  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .btn_n         (btn_n[i]),
      .tick          (tick),
      .level_n       (level_n[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i]),
      .evt_n         (evt_n[i])
    );
  end

endmodule
